// File: rtl/vision_pkg.sv
// Shared constants, request record and fetch FSM encoding for the NCC
// descriptor loader.
package vision_pkg;

    localparam int unsigned FRAME_WORDS_DEF = 160;
    localparam int unsigned FRAME_ROWS_DEF  = 480;

    localparam int unsigned DESC_WORDS    = 16;
    localparam int unsigned DESC_ROWS     = 8;
    localparam int unsigned WORDS_PER_ROW = 2;

    typedef struct packed {
        logic [7:0] col;
        logic [8:0] row;
    } kp_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_DRAIN,
        ST_GAP
    } fetch_state_e;

endpackage

// File: rtl/kp_req_fifo.sv
// Synchronous keypoint request queue with registered full/empty flags.
module kp_req_fifo
    import vision_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  kp_req_t wdata_i,
    input  logic    pop_i,
    output kp_req_t rdata_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    kp_req_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic            full_q, empty_q;
    logic            push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == (PW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/desc_fetch_ctrl.sv
// NCC descriptor loader: pops 8x8 keypoint windows, issues 16 frame-buffer
// reads per window and streams the returned words to ncc in row-major order.
module desc_fetch_ctrl
    import vision_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int unsigned FRAME_ROWS  = FRAME_ROWS_DEF,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAX_OUT     = 4,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kp_valid,
    output logic              kp_ready,
    input  logic [7:0]        kp_col,
    input  logic [8:0]        kp_row,
    output logic              kp_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [31:0]       mem_rd_data,
    output logic              desc_data_ready,
    output logic [31:0]       desc_data_in,
    output logic              desc_start,
    output logic              desc_done,
    output logic              busy
);

    localparam int unsigned CNT_W       = 5;
    localparam int unsigned OUT_W       = $clog2(MAX_OUT + 1);
    localparam int unsigned GAP_W       = $clog2(GAP_CYCLES + 1);
    localparam int unsigned DROP_CYCLES = 16;

    fetch_state_e      state_q;
    kp_req_t           req_q, fifo_head, fifo_wdata;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [ADDR_W-1:0] addr_q, mem_addr_q, base;
    logic [CNT_W-1:0]  issued_q, received_q;
    logic [OUT_W-1:0]  outst_q;
    logic [GAP_W-1:0]  gap_q;
    logic [4:0]        drop_q;
    logic              kp_err_q, mem_rd_en_q, rdy_q, start_q, last_q, done_q;
    logic [31:0]       data_q;
    logic              rx_acc, can_issue, col_bad, row_bad;

    assign fifo_wdata = '{col: kp_col, row: kp_row};

    kp_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (kp_valid),
        .wdata_i(fifo_wdata),
        .pop_i  (fifo_pop),
        .rdata_o(fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Requests stay queued until the post-reset drop window has expired,
    // so stale beats from an abandoned descriptor can never be mistaken for data.
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty && (drop_q == '0);

    assign rx_acc = mem_rd_valid && (drop_q == '0) && (outst_q != '0) &&
                    ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

    assign can_issue = (state_q == ST_ISSUE) &&
                       (issued_q < CNT_W'(DESC_WORDS)) &&
                       (outst_q < OUT_W'(MAX_OUT));

    assign col_bad = ({1'b0, req_q.col} + 9'd1) >= 9'(FRAME_WORDS);
    assign row_bad = ({1'b0, req_q.row} + 10'(DESC_ROWS - 1)) >= 10'(FRAME_ROWS);
    assign base    = ADDR_W'(req_q.row) * ADDR_W'(FRAME_WORDS) + ADDR_W'(req_q.col);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            outst_q     <= '0;
            gap_q       <= '0;
            drop_q      <= 5'(DROP_CYCLES);
            kp_err_q    <= 1'b0;
            mem_rd_en_q <= 1'b0;
            rdy_q       <= 1'b0;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            kp_err_q    <= 1'b0;
            mem_rd_en_q <= 1'b0;
            rdy_q       <= rx_acc;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= last_q;

            if (drop_q != '0) begin
                drop_q <= drop_q - 5'd1;
            end

            if (rx_acc) begin
                data_q     <= mem_rd_data;
                start_q    <= (received_q == '0);
                last_q     <= (received_q == CNT_W'(DESC_WORDS - 1));
                received_q <= received_q + CNT_W'(1);
            end

            if (can_issue && !rx_acc) begin
                outst_q <= outst_q + OUT_W'(1);
            end else if (rx_acc && !can_issue) begin
                outst_q <= outst_q - OUT_W'(1);
            end

            // Left word -> +1, right word -> down one row back to the left column.
            if (can_issue) begin
                mem_rd_en_q <= 1'b1;
                mem_addr_q  <= addr_q;
                issued_q    <= issued_q + CNT_W'(1);
                addr_q      <= addr_q + (issued_q[0] ? ADDR_W'(FRAME_WORDS - 1) : ADDR_W'(1));
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        req_q   <= fifo_head;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (col_bad || row_bad) begin
                        kp_err_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        addr_q     <= base;
                        issued_q   <= '0;
                        received_q <= '0;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (can_issue && (issued_q == CNT_W'(DESC_WORDS - 1))) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (received_q == CNT_W'(DESC_WORDS)) begin
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign kp_ready        = !fifo_full;
    assign kp_err          = kp_err_q;
    assign mem_rd_en       = mem_rd_en_q;
    assign mem_addr        = mem_addr_q;
    assign desc_data_ready = rdy_q;
    assign desc_data_in    = data_q;
    assign desc_start      = start_q;
    assign desc_done       = done_q;
    assign busy            = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_desc_fetch_ctrl.sv
// Self-checking bench for desc_fetch_ctrl: request table, in-order memory
// model returning the address as data, and word/address scoreboards.
module tb_desc_fetch_ctrl;

    localparam int unsigned FW  = 160;
    localparam int unsigned GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        kp_valid = 1'b0;
    logic        kp_ready;
    logic [7:0]  kp_col = '0;
    logic [8:0]  kp_row = '0;
    logic        kp_err;
    logic        mem_rd_en;
    logic [16:0] mem_addr;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic        desc_data_ready;
    logic [31:0] desc_data_in;
    logic        desc_start;
    logic        desc_done;
    logic        busy;

    desc_fetch_ctrl #(
        .FRAME_WORDS(FW),
        .FRAME_ROWS (480),
        .ADDR_W     (17),
        .FIFO_DEPTH (4),
        .MAX_OUT    (4),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .kp_valid       (kp_valid),
        .kp_ready       (kp_ready),
        .kp_col         (kp_col),
        .kp_row         (kp_row),
        .kp_err         (kp_err),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .desc_data_ready(desc_data_ready),
        .desc_data_in   (desc_data_in),
        .desc_start     (desc_start),
        .desc_done      (desc_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] col;
        logic [8:0] row;
        bit         exp_err;
    } vec_t;

    typedef struct {
        logic [16:0] addr;
        int          due;
    } pend_t;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    pend_t       pend_q[$];

    int cyc = 0;
    int mem_lat = 2;
    int bench_out = 0;
    int max_out_seen = 0;
    int rd_idx = 0;
    int word_idx = 0;
    int rden_count = 0;
    int ready_count = 0;
    int done_count = 0;
    int err_count = 0;
    int last_word_cyc = 0;
    bit have_last = 1'b0;
    int rden_gap = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected / missing", name);
    endtask

    // Memory model and output monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (mem_rd_en) begin
            chk("outstanding_below_max", 32'(bench_out < 4), 32'd1);
            if (exp_addr_q.size() == 0) begin
                flag("spurious_mem_rd_en");
            end else begin
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (rd_idx == 0 && have_last) rden_gap = cyc - last_word_cyc;
            rd_idx = (rd_idx + 1) % 16;
            rden_count++;
            pend_q.push_back('{addr: mem_addr, due: cyc + mem_lat});
            bench_out++;
            if (bench_out > max_out_seen) max_out_seen = bench_out;
        end

        if (desc_data_ready) begin
            if (exp_data_q.size() == 0) begin
                flag("unexpected_desc_word");
            end else begin
                chk("desc_data_in", desc_data_in, exp_data_q.pop_front());
                chk("desc_start", 32'(desc_start), 32'(word_idx == 0));
            end
            if (word_idx == 0 && have_last)
                chk("start_spacing_ge_7", 32'((cyc - last_word_cyc) >= 7), 32'd1);
            word_idx = (word_idx + 1) % 16;
            ready_count++;
            if (word_idx == 0) begin
                last_word_cyc = cyc;
                have_last = 1'b1;
            end
        end else if (desc_start) begin
            flag("desc_start_without_word");
        end

        if (desc_done) begin
            chk("desc_done_timing", 32'(have_last && (cyc == last_word_cyc + 1)), 32'd1);
            done_count++;
        end
        if (kp_err) err_count++;

        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = {15'd0, pend_q[0].addr};
            void'(pend_q.pop_front());
            bench_out--;
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = $urandom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_req(input logic [7:0] col, input logic [8:0] row);
        int n = 0;
        int base;
        while (!kp_ready && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) flag("kp_ready_timeout");
        if (!((int'(col) + 1 >= 160) || (int'(row) + 7 >= 480))) begin
            base = int'(row) * 160 + int'(col);
            for (int r = 0; r < 8; r++) begin
                for (int w = 0; w < 2; w++) begin
                    exp_addr_q.push_back(17'(base + r * 160 + w));
                    exp_data_q.push_back(32'(base + r * 160 + w));
                end
            end
        end
        kp_valid = 1'b1;
        kp_col   = col;
        kp_row   = row;
        tick();
        kp_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_data_q.size() != 0 || pend_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk("idle_within_budget", 32'(n < 3000), 32'd1);
        repeat (3) tick();
    endtask

    vec_t vecs[6];

    initial begin
        int d0, e0, r0, q0, n;

        vecs[0] = '{col: 8'd10,  row: 9'd20,  exp_err: 1'b0};
        vecs[1] = '{col: 8'd159, row: 9'd0,   exp_err: 1'b1};
        vecs[2] = '{col: 8'd0,   row: 9'd473, exp_err: 1'b1};
        vecs[3] = '{col: 8'd158, row: 9'd472, exp_err: 1'b0};
        vecs[4] = '{col: 8'd0,   row: 9'd0,   exp_err: 1'b0};
        vecs[5] = '{col: 8'd77,  row: 9'd200, exp_err: 1'b0};

        repeat (3) tick();
        chk("reset_kp_ready", 32'(kp_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("reset_desc_ready", 32'(desc_data_ready), 32'd0);
        chk("reset_desc_data", desc_data_in, 32'd0);
        chk("reset_kp_err", 32'(kp_err), 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            d0 = done_count; e0 = err_count; q0 = rden_count;
            push_req(vecs[i].col, vecs[i].row);
            wait_idle();
            chk("vec_kp_err", 32'(err_count - e0), 32'(vecs[i].exp_err));
            chk("vec_rd_count", 32'(rden_count - q0), vecs[i].exp_err ? 32'd0 : 32'd16);
            chk("vec_done_count", 32'(done_count - d0), vecs[i].exp_err ? 32'd0 : 32'd1);
            chk("vec_busy_low", 32'(busy), 32'd0);
        end

        // Long memory latency: throttling must kick in at MAX_OUT.
        mem_lat = 10;
        max_out_seen = 0;
        d0 = done_count;
        push_req(8'd5, 9'd5);
        wait_idle();
        chk("lat10_done", 32'(done_count - d0), 32'd1);
        chk("lat10_max_outstanding", 32'(max_out_seen), 32'd4);

        // Back-to-back requests fill the queue.
        mem_lat = 2;
        d0 = done_count;
        for (int i = 0; i < 5; i++) push_req(8'(i * 3), 9'(i * 50));
        chk("queue_full_kp_ready", 32'(kp_ready), 32'd0);
        n = 0;
        while (!kp_ready && n < 200) begin tick(); n++; end
        chk("kp_ready_rises", 32'(kp_ready), 32'd1);
        wait_idle();
        chk("b2b_done_count", 32'(done_count - d0), 32'd5);

        // Second request arriving during DRAIN waits out the gap.
        mem_lat = 10;
        d0 = done_count; q0 = rden_count;
        push_req(8'd40, 9'd100);
        n = 0;
        while (rden_count - q0 < 16 && n < 500) begin tick(); n++; end
        chk("drain_reached", 32'(rden_count - q0), 32'd16);
        rden_gap = -1;
        push_req(8'd41, 9'd101);
        chk("drain_busy", 32'(busy), 32'd1);
        wait_idle();
        chk("drain_next_after_gap", 32'(rden_gap > int'(GAP)), 32'd1);
        chk("drain_done_count", 32'(done_count - d0), 32'd2);

        // Reset mid-descriptor with stale beats still returning.
        mem_lat = 2;
        r0 = ready_count;
        push_req(8'd20, 9'd30);
        n = 0;
        while (ready_count - r0 < 6 && n < 500) begin tick(); n++; end
        chk("six_words_before_reset", 32'(ready_count - r0), 32'd6);
        rst = 1'b0;
        tick();
        exp_data_q.delete();
        exp_addr_q.delete();
        while (pend_q.size() > 2) void'(pend_q.pop_back());
        bench_out = pend_q.size();
        word_idx = 0; rd_idx = 0; have_last = 1'b0;
        tick();
        rst = 1'b1;
        chk("post_reset_kp_ready", 32'(kp_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_desc_ready", 32'(desc_data_ready), 32'd0);
        r0 = ready_count;
        repeat (20) tick();
        chk("no_words_after_reset", 32'(ready_count - r0), 32'd0);
        d0 = done_count;
        push_req(8'd12, 9'd34);
        wait_idle();
        chk("fresh_after_reset_done", 32'(done_count - d0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
